// File: rtl/vga_regs_pkg.sv
// Shared constants, address map and attribute types for the frame-synchronous
// VGA register front end.
package vga_regs_pkg;

  localparam int unsigned VACTIVE        = 480;
  localparam int unsigned NUM_SPRITES    = 3;
  localparam int unsigned NUM_BOUNDARIES = 4;
  localparam int unsigned ADDR_W         = 6;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned COORD_W        = 10;
  localparam int unsigned IMG_W          = 5;
  localparam int unsigned HC_W           = 11;
  localparam int unsigned VC_W           = 10;
  localparam int unsigned FRAME_W        = 8;

  localparam logic [ADDR_W-1:0] ADDR_BOUNDARY1   = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_BOUNDARY2   = 6'h01;
  localparam logic [ADDR_W-1:0] ADDR_BOUNDARY3   = 6'h02;
  localparam logic [ADDR_W-1:0] ADDR_BOUNDARY4   = 6'h03;
  localparam logic [ADDR_W-1:0] ADDR_SPRITE1_X   = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_SPRITE1_Y   = 6'h05;
  localparam logic [ADDR_W-1:0] ADDR_SPRITE1_IMG = 6'h06;
  localparam logic [ADDR_W-1:0] ADDR_SPRITE2_X   = 6'h07;
  localparam logic [ADDR_W-1:0] ADDR_SPRITE2_Y   = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_SPRITE2_IMG = 6'h09;
  localparam logic [ADDR_W-1:0] ADDR_SPRITE3_X   = 6'h0A;
  localparam logic [ADDR_W-1:0] ADDR_SPRITE3_Y   = 6'h0B;
  localparam logic [ADDR_W-1:0] ADDR_SPRITE3_IMG = 6'h0C;
  localparam logic [ADDR_W-1:0] ADDR_COMMIT      = 6'h0D;
  localparam logic [ADDR_W-1:0] ADDR_STATUS      = 6'h0E;
  localparam logic [ADDR_W-1:0] ADDR_CTRL        = 6'h0F;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [IMG_W-1:0]   img;
  } sprite_attr_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

  typedef enum logic [1:0] {
    FLD_X   = 2'd0,
    FLD_Y   = 2'd1,
    FLD_IMG = 2'd2
  } sprite_field_e;

  // Sprite registers are laid out three words per sprite starting at SPRITE1_X.
  function automatic logic [1:0] sprite_index(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - ADDR_SPRITE1_X;
    return 2'(off / 6'd3);
  endfunction

  function automatic sprite_field_e sprite_field(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - ADDR_SPRITE1_X;
    return sprite_field_e'(2'(off % 6'd3));
  endfunction

endpackage

// File: rtl/vga_frame_regs_vblank_detect.sv
// Vertical-blank level and single-cycle start pulse derived from the raster
// counters; the registered level keeps the pulse to one cycle per frame.
import vga_regs_pkg::*;

module vblank_detect #(
  parameter int unsigned VACTIVE_LINE = VACTIVE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [HC_W-1:0] hcount,
  input  logic [VC_W-1:0] vcount,
  output logic            vblank_c,
  output logic            vblank_start_c
);

  logic vblank_q, vblank_d;

  always_comb begin
    vblank_c       = vcount >= VC_W'(VACTIVE_LINE);
    vblank_d       = vblank_c;
    vblank_start_c = (vcount == VC_W'(VACTIVE_LINE)) && (hcount == '0) && !vblank_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vblank_q <= 1'b0;
    else       vblank_q <= vblank_d;
  end

endmodule

// File: rtl/vga_frame_regs.sv
// Shadow/active attribute registers for the VGA renderer with atomic commit at
// vblank start, plus frame counter, status word and vblank interrupt.
import vga_regs_pkg::*;

module vga_frame_regs #(
  parameter int unsigned VACTIVE_LINE = VACTIVE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chipselect,
  input  logic               write,
  input  logic               read,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  input  logic [HC_W-1:0]    hcount,
  input  logic [VC_W-1:0]    vcount,
  output logic [COORD_W-1:0] boundary_1,
  output logic [COORD_W-1:0] boundary_2,
  output logic [COORD_W-1:0] boundary_3,
  output logic [COORD_W-1:0] boundary_4,
  output logic [COORD_W-1:0] sprite1_x,
  output logic [COORD_W-1:0] sprite2_x,
  output logic [COORD_W-1:0] sprite3_x,
  output logic [COORD_W-1:0] sprite1_y,
  output logic [COORD_W-1:0] sprite2_y,
  output logic [COORD_W-1:0] sprite3_y,
  output logic [IMG_W-1:0]   sprite1_img,
  output logic [IMG_W-1:0]   sprite2_img,
  output logic [IMG_W-1:0]   sprite3_img,
  output logic               irq
);

  sprite_attr_t       spr_shadow_q [NUM_SPRITES];
  sprite_attr_t       spr_shadow_d [NUM_SPRITES];
  sprite_attr_t       spr_active_q [NUM_SPRITES];
  sprite_attr_t       spr_active_d [NUM_SPRITES];
  logic [COORD_W-1:0] bnd_shadow_q [NUM_BOUNDARIES];
  logic [COORD_W-1:0] bnd_shadow_d [NUM_BOUNDARIES];
  logic [COORD_W-1:0] bnd_active_q [NUM_BOUNDARIES];
  logic [COORD_W-1:0] bnd_active_d [NUM_BOUNDARIES];

  commit_state_e      state_q, state_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic               irq_enable_q, irq_enable_d;
  logic               irq_pending_q, irq_pending_d;
  logic               irq_q, irq_d;
  logic [DATA_W-1:0]  readdata_q, readdata_d;

  logic               wr_en_c, rd_en_c, commit_wr_c, ctrl_wr_c, do_copy_c;
  logic               vblank_c, vblank_start_c;
  logic [1:0]         spr_idx_c;
  sprite_field_e      spr_fld_c;
  logic [DATA_W-1:0]  rd_mux_c;
  logic               unused_wdata_c;

  vblank_detect #(.VACTIVE_LINE(VACTIVE_LINE)) u_vblank_detect (
    .clk            (clk),
    .reset          (reset),
    .hcount         (hcount),
    .vcount         (vcount),
    .vblank_c       (vblank_c),
    .vblank_start_c (vblank_start_c)
  );

  assign wr_en_c        = chipselect & write;
  assign rd_en_c        = chipselect & read;
  assign commit_wr_c    = wr_en_c && (address == ADDR_COMMIT);
  assign ctrl_wr_c      = wr_en_c && (address == ADDR_CTRL);
  assign spr_idx_c      = sprite_index(address);
  assign spr_fld_c      = sprite_field(address);
  assign unused_wdata_c = ^writedata[DATA_W-1:COORD_W];

  // Shadow register writes; upper data bits beyond each field are dropped.
  always_comb begin
    spr_shadow_d = spr_shadow_q;
    bnd_shadow_d = bnd_shadow_q;
    if (wr_en_c) begin
      case (address)
        ADDR_BOUNDARY1, ADDR_BOUNDARY2, ADDR_BOUNDARY3, ADDR_BOUNDARY4:
          bnd_shadow_d[address[1:0]] = writedata[COORD_W-1:0];
        ADDR_SPRITE1_X, ADDR_SPRITE1_Y, ADDR_SPRITE1_IMG,
        ADDR_SPRITE2_X, ADDR_SPRITE2_Y, ADDR_SPRITE2_IMG,
        ADDR_SPRITE3_X, ADDR_SPRITE3_Y, ADDR_SPRITE3_IMG: begin
          case (spr_fld_c)
            FLD_X:   spr_shadow_d[spr_idx_c].x   = writedata[COORD_W-1:0];
            FLD_Y:   spr_shadow_d[spr_idx_c].y   = writedata[COORD_W-1:0];
            FLD_IMG: spr_shadow_d[spr_idx_c].img = writedata[IMG_W-1:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Readback mux; COMMIT and unmapped addresses read as zero.
  always_comb begin
    rd_mux_c = '0;
    case (address)
      ADDR_BOUNDARY1, ADDR_BOUNDARY2, ADDR_BOUNDARY3, ADDR_BOUNDARY4:
        rd_mux_c = DATA_W'(bnd_shadow_q[address[1:0]]);
      ADDR_SPRITE1_X, ADDR_SPRITE1_Y, ADDR_SPRITE1_IMG,
      ADDR_SPRITE2_X, ADDR_SPRITE2_Y, ADDR_SPRITE2_IMG,
      ADDR_SPRITE3_X, ADDR_SPRITE3_Y, ADDR_SPRITE3_IMG: begin
        case (spr_fld_c)
          FLD_X:   rd_mux_c = DATA_W'(spr_shadow_q[spr_idx_c].x);
          FLD_Y:   rd_mux_c = DATA_W'(spr_shadow_q[spr_idx_c].y);
          FLD_IMG: rd_mux_c = DATA_W'(spr_shadow_q[spr_idx_c].img);
          default: ;
        endcase
      end
      ADDR_STATUS:
        rd_mux_c = {frame_count_q, 5'd0, irq_pending_q, vblank_c, state_q == ST_PENDING};
      ADDR_CTRL:
        rd_mux_c = {15'd0, irq_enable_q};
      default: ;
    endcase
  end

  // Commit FSM; the copy samples shadow_q so a same-cycle shadow write lands next frame.
  always_comb begin
    state_d   = state_q;
    do_copy_c = 1'b0;
    case (state_q)
      ST_IDLE:    if (commit_wr_c) state_d = ST_PENDING;
      ST_PENDING: if (vblank_start_c) begin
        state_d   = ST_IDLE;
        do_copy_c = 1'b1;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    spr_active_d = spr_active_q;
    bnd_active_d = bnd_active_q;
    if (do_copy_c) begin
      spr_active_d = spr_shadow_q;
      bnd_active_d = bnd_shadow_q;
    end
  end

  // Frame counter, interrupt (set beats clear) and registered read data.
  always_comb begin
    frame_count_d = frame_count_q;
    irq_enable_d  = irq_enable_q;
    irq_pending_d = irq_pending_q;
    readdata_d    = readdata_q;
    if (vblank_start_c) frame_count_d = frame_count_q + 8'd1;
    if (ctrl_wr_c) begin
      irq_enable_d = writedata[0];
      if (writedata[1]) irq_pending_d = 1'b0;
    end
    if (vblank_start_c) irq_pending_d = 1'b1;
    irq_d = irq_pending_d & irq_enable_d;
    if (rd_en_c) readdata_d = rd_mux_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spr_shadow_q  <= '{default: '0};
      spr_active_q  <= '{default: '0};
      bnd_shadow_q  <= '{default: '0};
      bnd_active_q  <= '{default: '0};
      state_q       <= ST_IDLE;
      frame_count_q <= '0;
      irq_enable_q  <= 1'b0;
      irq_pending_q <= 1'b0;
      irq_q         <= 1'b0;
      readdata_q    <= '0;
    end else begin
      spr_shadow_q  <= spr_shadow_d;
      spr_active_q  <= spr_active_d;
      bnd_shadow_q  <= bnd_shadow_d;
      bnd_active_q  <= bnd_active_d;
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
      irq_enable_q  <= irq_enable_d;
      irq_pending_q <= irq_pending_d;
      irq_q         <= irq_d;
      readdata_q    <= readdata_d;
    end
  end

  assign readdata    = readdata_q;
  assign irq         = irq_q;
  assign boundary_1  = bnd_active_q[0];
  assign boundary_2  = bnd_active_q[1];
  assign boundary_3  = bnd_active_q[2];
  assign boundary_4  = bnd_active_q[3];
  assign sprite1_x   = spr_active_q[0].x;
  assign sprite2_x   = spr_active_q[1].x;
  assign sprite3_x   = spr_active_q[2].x;
  assign sprite1_y   = spr_active_q[0].y;
  assign sprite2_y   = spr_active_q[1].y;
  assign sprite3_y   = spr_active_q[2].y;
  assign sprite1_img = spr_active_q[0].img;
  assign sprite2_img = spr_active_q[1].img;
  assign sprite3_img = spr_active_q[2].img;

endmodule

// File: doc/vga_frame_regs.md
# vga_frame_regs

Frame-synchronous register front end for the VGA sprite/background renderer, sitting between the Avalon-MM slave port and the renderer's attribute inputs. Software writes river boundaries and sprite attributes into shadow registers, then requests a commit. The block copies every shadow into the active set atomically at the start of vertical blank, so no frame is ever drawn with half-updated attributes. It also maintains a frame counter, a status word and a vblank interrupt.

## Interface
- `VACTIVE`, 480: first non-visible line; vblank start is `vcount == VACTIVE && hcount == 0`.
- `clk`  in  1  50 MHz system clock.
- `reset`  in  1  Asynchronous, active-high.
- `chipselect`, `write`, `read`  in  1 each  Avalon slave strobes.
- `address`  in  6  Word address.
- `writedata`  in  16  Write data.
- `readdata`  out  16  Registered read data.
- `hcount`  in  11  From `vga_counters`.
- `vcount`  in  10  From `vga_counters`.
- `boundary_1`..`boundary_4`  out  10 each  Active river boundaries.
- `sprite1_x`..`sprite3_x`  out  10 each  Active sprite x positions.
- `sprite1_y`..`sprite3_y`  out  10 each  Active sprite y; bit 0 = visible.
- `sprite1_img`..`sprite3_img`  out  5 each  Active image select.
- `irq`  out  1  `irq_pending & irq_enable`.

## Operation
- **Address map:**
  - 0x00–0x03: boundary_1..4, bits [9:0].
  - 0x04+3k, 0x05+3k, 0x06+3k (k = 0..2): sprite k+1 x [9:0], y [9:0], img [4:0].
  - 0x0D: COMMIT, write-only; data ignored.
  - 0x0E: STATUS, read-only; bit 0 commit_pending, bit 1 vblank, bit 2 irq_pending, bits [15:8] frame_count.
  - 0x0F: CTRL. Bit 0 irq_enable (read/write). Writing 1 to bit 1 clears irq_pending; bit 1 reads 0.
- **Writes:** `chipselect & write` to 0x00–0x0C updates only the shadow register; upper data bits are dropped. Writes to 0x10–0x3F are ignored.
- **Reads:** 0x00–0x0C return the shadow value, zero-extended. Unmapped addresses read 0.
- **COMMIT write:** sets commit_pending.
- **vblank start event:**
  - If commit_pending: copy all 13 shadows to active and clear commit_pending.
  - frame_count increments, wrapping 255→0.
  - irq_pending is set.
- **vblank flag:** `vcount >= VACTIVE`, combinational from the counters.
- **Two-state commit FSM:**
  - IDLE → PENDING on a COMMIT write.
  - PENDING → IDLE on vblank start, performing the copy.
  - A COMMIT write while PENDING has no additional effect.

## Timing
- Reset values: all shadow and active registers 0 (all sprites hidden, both boundary_3 and boundary_4 0), commit_pending 0, frame_count 0, irq_enable 0, irq_pending 0, readdata 0, irq 0.
- Read latency: 1 cycle. `readdata` is valid on the clock after `chipselect & read` and holds until the next read.
- Active outputs change only on the clock edge of the vblank-start cycle. The renderer sees new values from line `VACTIVE`, which is off-screen.
- COMMIT write in the same cycle as vblank start: pending is set, but the copy happens at the next frame's vblank start.
- Shadow write in the same cycle as the copy: active receives the old shadow value; the shadow holds the new value afterwards.
- irq clear in the same cycle as vblank start: set wins, so irq_pending stays 1.
- STATUS read in the vblank-start cycle returns pre-event values.
- Reset asserted mid-frame or while PENDING: all state returns to reset values immediately; no partial copy occurs.

## Structure
- Package `vga_regs_pkg`:
  - Address constants `ADDR_BOUNDARY1`..`ADDR_CTRL`.
  - `sprite_attr_t` packed struct `{x[9:0], y[9:0], img[4:0]}`.
  - `NUM_SPRITES = 3`.
- Shadow and active sprite sets are arrays of `sprite_attr_t`, indexed by `(address-4)/3` decode.
- One sub-module, `vblank_detect`: registers the vblank level and produces the single-cycle start pulse from `hcount`/`vcount` and `VACTIVE`.

## Test plan
- **Reset:** assert reset mid-frame → all active outputs 0, `irq` 0, STATUS reads 0x0000.
- **Commit:** write sprite1_x = 100, y = 0x0C9, img = 2, then COMMIT at vcount 200 → outputs stay 0 until vcount 480/hcount 0, then read 100/0x0C9/2. STATUS bit 0 is 1 before the copy and 0 after.
- **No commit:** write boundary_1 = 50 with no COMMIT → active boundary_1 stays 0 across three frames; register readback returns 50; frame_count advances 0→3.
- **Same-cycle COMMIT:** COMMIT coincident with the vblank-start cycle → no copy this frame; copy occurs at the next vblank start.
- **Interrupt:** CTRL = 1, run one frame → `irq` rises at vblank start. Write CTRL = 2 → `irq` falls the next cycle. A clear coincident with vblank start → `irq` stays 1.
- **Wrap and unmapped access:** 256 frames → frame_count wraps to 0. Write 0xFFFF to 0x20 → no register changes; reading 0x20 returns 0.
